// File: rtl/opcode_sequencer.sv
// opcode_sequencer: small writable program memory of 16-bit Datapath control
// words, issued one per cycle (RUN) or one per step pulse (PAUSE).
// Optional build macro SEQ_LOOP_EN: on halt word or end of memory the program
// restarts at word 0 instead of finishing; done is never asserted.
module opcode_sequencer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  output logic [15:0]   OPcode,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam int unsigned OW = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [OW-1:0] mem [DEPTH];
  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [AW-1:0] pc_n;
  logic [OW-1:0] opcode_n;
  logic [OW-1:0] word;
  logic          issue;
  logic          mem_we;

  // Program memory is writable only while no program is in flight.
  assign mem_we = load_en && ((state == S_IDLE) || (state == S_DONE));
  assign word   = mem[pc];

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_addr] <= load_data;
    end
  end

  // Next-state, next-pc and next-OPcode decode.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    opcode_n = '0;
    issue    = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_n    = '0;
          state_n = step_mode ? S_PAUSE : S_RUN;
        end
      end
      S_RUN: begin
        if (start) begin
          pc_n    = '0;
          state_n = S_IDLE;
        end else begin
          issue = 1'b1;
        end
      end
      S_PAUSE: begin
        if (start) begin
          pc_n    = '0;
          state_n = S_IDLE;
        end else if (step) begin
          issue = 1'b1;
        end
      end
      default: begin
        pc_n    = '0;
        state_n = S_IDLE;
      end
    endcase

    // Issue rule shared by free-run cycles and step pulses.
    if (issue) begin
      if (word == HALT_WORD) begin
`ifdef SEQ_LOOP_EN
        pc_n = '0;
`else
        state_n = S_DONE;
`endif
      end else begin
        opcode_n = word;
        if (pc == LAST_ADDR) begin
          pc_n = '0;
`ifndef SEQ_LOOP_EN
          state_n = S_DONE;
`endif
        end else begin
          pc_n = pc + AW'(1);
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= '0;
      OPcode <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      OPcode <= opcode_n;
      busy   <= (state_n == S_RUN) || (state_n == S_PAUSE);
      done   <= (state_n == S_DONE);
    end
  end

endmodule
